pll_ctrl: RTL
=============

# pll_ctrl

Reset and lock sequencer for the clock-generation MMCM. It drives the MMCM reset and qualifies its `locked` output. It releases the synchronous resets of the generated clock domains in a fixed staggered order, and restarts the MMCM on lock loss, lock timeout or a software request. It runs on the 50 MHz reference clock, beside the MMCM wrapper, and feeds the core's per-domain reset synchronizers.

## Interface
Parameters:
- `RST_HOLD_CYCLES`, 16: cycles `pll_rst` is held high per restart.
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized-locked cycles required before release.
- `LOCK_TIMEOUT_CYCLES`, 2000000: maximum wait for lock (40 ms at 50 MHz) before retry.
- `NUM_DOMAINS`, 3: number of domain resets, bit 0 released first.
- `STAGGER_CYCLES`, 8: gap between successive domain releases.

Ports:
- `refclk`, in, 1: sole clock, 50 MHz.
- `rst`, in, 1: synchronous, active-high reset.
- `locked_in`, in, 1: MMCM `locked`; asynchronous to this block.
- `restart_req`, in, 1: single-cycle request to force a full restart.
- `pll_rst`, out, 1: MMCM reset, registered.
- `domain_rst`, out, `NUM_DOMAINS`: active-high domain resets in the `refclk` domain; each consumer resynchronizes them.
- `ready`, out, 1: high while all domains are released and lock is good.
- `lock_lost`, out, 1: one-cycle pulse when lock drops in RUN.
- `retry_count`, out, 4: saturating count of lock timeouts since `rst`.

## Operation
- `locked_in` passes through a 2-flop synchronizer; `locked_s` is the synchronizer output. All decisions use `locked_s`.
- A single down/up counter is shared across states. Its width is `$clog2` of the largest cycle parameter plus 1.
- **States:** RESET_PLL, WAIT_LOCK, STABILIZE, RELEASE, RUN.
- **RESET_PLL:**
  - Outputs: `pll_rst`=1, all `domain_rst`=1, `ready`=0.
  - After `RST_HOLD_CYCLES` cycles in this state, go to WAIT_LOCK.
- **WAIT_LOCK:**
  - `pll_rst`=0. The counter counts timeout cycles.
  - `locked_s`=1: go to STABILIZE and clear the counter.
  - Counter reaches `LOCK_TIMEOUT_CYCLES`: increment `retry_count` (saturating at 15) and go to RESET_PLL.
- **STABILIZE:**
  - `locked_s`=0 at any point: go back to WAIT_LOCK with a fresh timeout.
  - `LOCK_STABLE_CYCLES` consecutive high cycles: go to RELEASE.
- **RELEASE:**
  - `domain_rst[i]` falls `i*STAGGER_CYCLES` cycles after entry; bits that have fallen stay low.
  - After the last bit falls, go to RUN.
  - `locked_s`=0 here: reassert all `domain_rst` and go to RESET_PLL. `lock_lost` does not pulse.
- **RUN:**
  - `ready`=1.
  - `locked_s`=0: pulse `lock_lost`, reassert all `domain_rst`, drop `ready`, go to RESET_PLL.
- **`restart_req`:**
  - In any state except RESET_PLL: go to RESET_PLL on the next edge.
  - In RESET_PLL: restarts the hold count.
  - Takes priority over a simultaneous lock loss. `lock_lost` still pulses if the block was in RUN.
  - Does not change `retry_count`.
- **`rst`:** overrides everything in any state. It returns the block to RESET_PLL with the counter cleared, `retry_count`=0 and the synchronizer flops cleared.

## Timing
- **Reset values:**
  - `pll_rst`=1, `domain_rst`=all 1s.
  - `ready`=0, `lock_lost`=0, `retry_count`=0.
  - State = RESET_PLL.
- All outputs are registered; no combinational paths from inputs to outputs.
- Let edge E0 be the first rising edge with `rst`=0.
  - `pll_rst` falls after edge E0+`RST_HOLD_CYCLES`.
- `locked_in` rising reaches STABILIZE after 3 edges: 2 synchronizer stages plus 1 state register.
- **Lock drop in RUN:**
  - Lock-drop latency is the same 3 edges.
  - On the edge that takes the block into RESET_PLL: `domain_rst` go high, `ready` falls and `lock_lost` pulses.
  - `pll_rst` is high on the following cycle.
- `ready` rises on the same edge that releases the last `domain_rst` bit.

## Structure
- Package `pll_ctrl_pkg` holds:
  - the state encoding (5 states, binary);
  - the `retry_count` width constant (4);
  - the saturation value (15).
- Sub-module `sync_2ff`: generic 2-flop synchronizer with a synchronous reset value input. It is reused for the per-domain reset synchronizers in the core.

## Test plan
Bench parameters: `RST_HOLD_CYCLES`=4, `LOCK_STABLE_CYCLES`=8, `LOCK_TIMEOUT_CYCLES`=100, `STAGGER_CYCLES`=2, `NUM_DOMAINS`=3.

1. **Normal bring-up:** `locked_in` rises 10 cycles after `pll_rst` falls.
   - `domain_rst` goes 111 → 110 → 100 → 000 at 2-cycle spacing.
   - `ready`=1 with the last bit; `retry_count`=0.
2. **Lock timeout:** `locked_in` held low.
   - `pll_rst` re-pulses for 4 cycles every 100+4 cycles.
   - `retry_count` increments each timeout and saturates at 15 after 15 timeouts.
3. **Glitchy lock:** `locked_in` high for 5 cycles, low for 1, then high.
   - STABILIZE aborts; release happens only after 8 clean cycles.
4. **Lock loss in RUN:** `locked_in` falls.
   - `lock_lost` is one pulse, 3 edges later; `ready`=0 and `domain_rst`=111 on the same edge.
   - `pll_rst`=1 next cycle; full re-sequence follows.
5. **`restart_req` during RELEASE** (after bit 0 released):
   - all `domain_rst` return to 111, `pll_rst` high for 4 cycles;
   - no `lock_lost` pulse; `retry_count` unchanged.
6. **`rst` asserted in RUN with `retry_count`=3:**
   - next edge gives `pll_rst`=1, `domain_rst`=111, `ready`=0, `retry_count`=0.

Source files
------------

// File: rtl/pll_ctrl_pkg.sv
// Shared definitions for the MMCM reset/lock sequencer.
// Holds the sequencer state encoding, the retry counter width and its
// saturation value, plus a small helper used to size the shared counter.
package pll_ctrl_pkg;

    // Sequencer states, binary encoded.
    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABILIZE = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4
    } pll_state_e;

    // Lock-timeout retry counter.
    localparam int                 RETRY_W   = 4;
    localparam logic [RETRY_W-1:0] RETRY_MAX = 4'd15;
    localparam logic [RETRY_W-1:0] RETRY_ONE = 4'd1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for slow or level signals crossing into i_clk.
// Latency: two i_clk edges from input change to o_q change.
// Ports: i_clk, i_rst (sync, active-high, loads i_rst_val), i_d (async in), o_q.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_rst_val,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= i_rst_val;
            r_sync <= i_rst_val;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_ctrl.sv
// MMCM reset and lock sequencer: pulses the MMCM reset, qualifies locked,
// releases the generated-domain resets in staggered order and restarts on
// lock loss, lock timeout or software request. All outputs are registered.
// Ports: i_refclk, i_rst (sync active-high), i_locked_in (async), i_restart_req,
//        o_pll_rst, o_domain_rst[NUM_DOMAINS], o_ready, o_lock_lost, o_retry_count.
module pll_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int RST_HOLD_CYCLES     = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 2000000,
    parameter int NUM_DOMAINS         = 3,
    parameter int STAGGER_CYCLES      = 8
) (
    input  logic                   i_refclk,
    input  logic                   i_rst,
    input  logic                   i_locked_in,
    input  logic                   i_restart_req,
    output logic                   o_pll_rst,
    output logic [NUM_DOMAINS-1:0] o_domain_rst,
    output logic                   o_ready,
    output logic                   o_lock_lost,
    output logic [RETRY_W-1:0]     o_retry_count
);

    // Cycles from RELEASE entry until the last domain reset falls.
    localparam int REL_CYCLES = (NUM_DOMAINS - 1) * STAGGER_CYCLES;

    // One counter serves every state, so it is sized for the longest wait.
    localparam int CNT_MAX = max_int(max_int(RST_HOLD_CYCLES, LOCK_STABLE_CYCLES),
                                     max_int(LOCK_TIMEOUT_CYCLES, REL_CYCLES));
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    // Terminal counts are "last value before the transition edge": the
    // counter is cleared on the edge that enters a state, so a state lasting
    // N cycles leaves on the edge where the counter holds N-1.
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] REL_LAST     = CNT_W'(max_int(REL_CYCLES, 1) - 1);

    pll_state_e             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_pll_rst;
    logic [NUM_DOMAINS-1:0] r_domain_rst;
    logic                   r_ready;
    logic                   r_lock_lost;
    logic [RETRY_W-1:0]     r_retry;

    pll_state_e             w_state_nxt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [NUM_DOMAINS-1:0] w_domain_rst_nxt;
    logic                   w_lock_lost_nxt;
    logic [RETRY_W-1:0]     w_retry_nxt;
    logic                   w_locked_s;

    // locked_in comes straight from the MMCM and is asynchronous here.
    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .i_clk     (i_refclk),
        .i_rst     (i_rst),
        .i_rst_val (1'b0),
        .i_d       (i_locked_in),
        .o_q       (w_locked_s)
    );

    always_ff @(posedge i_refclk) begin
        if (i_rst) begin
            r_state <= ST_RESET_PLL;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt + CNT_ONE;
        w_lock_lost_nxt = 1'b0;
        w_retry_nxt     = r_retry;

        case (r_state)
            ST_RESET_PLL: begin
                if (r_cnt == HOLD_LAST) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end
            end
            ST_WAIT_LOCK: begin
                // A lock seen on the timeout cycle still wins.
                if (w_locked_s) begin
                    w_state_nxt = ST_STABILIZE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_state_nxt = ST_RESET_PLL;
                    w_cnt_nxt   = '0;
                    w_retry_nxt = (r_retry == RETRY_MAX) ? r_retry : r_retry + RETRY_ONE;
                end
            end
            ST_STABILIZE: begin
                if (!w_locked_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == STABLE_LAST) begin
                    // With one domain or zero stagger there is nothing to pace.
                    w_state_nxt = (REL_CYCLES == 0) ? ST_RUN : ST_RELEASE;
                    w_cnt_nxt   = '0;
                end
            end
            ST_RELEASE: begin
                if (!w_locked_s) begin
                    w_state_nxt = ST_RESET_PLL;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == REL_LAST) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                end
            end
            ST_RUN: begin
                w_cnt_nxt = '0;
                if (!w_locked_s) begin
                    w_state_nxt     = ST_RESET_PLL;
                    w_lock_lost_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_RESET_PLL;
                w_cnt_nxt   = '0;
            end
        endcase

        // Software restart overrides every other transition, re-arms the
        // hold count when already resetting, and never counts as a retry.
        // A simultaneous lock loss in RUN still reports lock_lost.
        if (i_restart_req) begin
            w_state_nxt = ST_RESET_PLL;
            w_cnt_nxt   = '0;
            w_retry_nxt = r_retry;
        end
    end

    // Domain i is released once the RELEASE counter reaches i*STAGGER_CYCLES;
    // decoding from the next state/count keeps the release aligned with the
    // state edge, so the last bit and ready change together.
    always_comb begin
        w_domain_rst_nxt = '1;
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            if (w_state_nxt == ST_RUN) begin
                w_domain_rst_nxt[i] = 1'b0;
            end else if (w_state_nxt == ST_RELEASE &&
                         w_cnt_nxt >= CNT_W'(i * STAGGER_CYCLES)) begin
                w_domain_rst_nxt[i] = 1'b0;
            end
        end
    end

    // pll_rst follows the current state, so it lags the state register by one
    // edge: it rises the cycle after RESET_PLL is entered and falls the cycle
    // after it is left, giving exactly RST_HOLD_CYCLES of assertion.
    always_ff @(posedge i_refclk) begin
        if (i_rst) begin
            r_pll_rst    <= 1'b1;
            r_domain_rst <= '1;
            r_ready      <= 1'b0;
            r_lock_lost  <= 1'b0;
            r_retry      <= '0;
        end else begin
            r_pll_rst    <= (r_state == ST_RESET_PLL);
            r_domain_rst <= w_domain_rst_nxt;
            r_ready      <= (w_state_nxt == ST_RUN);
            r_lock_lost  <= w_lock_lost_nxt;
            r_retry      <= w_retry_nxt;
        end
    end

    assign o_pll_rst     = r_pll_rst;
    assign o_domain_rst  = r_domain_rst;
    assign o_ready       = r_ready;
    assign o_lock_lost   = r_lock_lost;
    assign o_retry_count = r_retry;

endmodule
